// File: rtl/video_timing.sv
// video_timing: raster timing generator (default 1024x768@60, XGA).
// Presents registered pixel coordinates, sync, blanking and line/frame
// strobes, and counts completed frames. Advances one pixel per enabled clk.
module video_timing #(
    parameter int unsigned H_ACTIVE = 1024,
    parameter int unsigned H_FP     = 24,
    parameter int unsigned H_SYNC   = 136,
    parameter int unsigned H_BP     = 160,
    parameter int unsigned V_ACTIVE = 768,
    parameter int unsigned V_FP     = 3,
    parameter int unsigned V_SYNC   = 6,
    parameter int unsigned V_BP     = 29,
    parameter bit          H_POL    = 1'b0,
    parameter bit          V_POL    = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_en,
    output logic       hsync,
    output logic       vsync,
    output logic       video_active,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEGIN = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_BEGIN = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [10:0] h_cnt;
    logic [9:0]  v_cnt;

    logic h_vis, v_vis, h_sync_win, v_sync_win;
    logic h_first, v_first, h_last, v_last;

    // Decode of the raster position currently being presented
    always_comb begin
        h_vis      = (h_cnt < H_ACT);
        v_vis      = (v_cnt < V_ACT);
        h_sync_win = (h_cnt >= HS_BEGIN) && (h_cnt < HS_END);
        v_sync_win = (v_cnt >= VS_BEGIN) && (v_cnt < VS_END);
        h_first    = (h_cnt == '0);
        v_first    = (v_cnt == '0);
        h_last     = (h_cnt == H_LAST);
        v_last     = (v_cnt == V_LAST);
    end

    // Raster counters: h wraps every line, v steps on the h wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 11'd1;
            end
        end
    end

    // Registered outputs; strobes are single-clk even with sparse enables
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync        <= !H_POL;
            vsync        <= !V_POL;
            video_active <= 1'b0;
            pix_x        <= '0;
            pix_y        <= '0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            frame_count  <= '0;
        end else if (pix_en) begin
            hsync        <= h_sync_win ? H_POL : !H_POL;
            // vsync only moves on line boundaries so it spans whole lines
            if (h_first)
                vsync    <= v_sync_win ? V_POL : !V_POL;
            video_active <= h_vis && v_vis;
            pix_x        <= h_vis ? h_cnt[9:0] : '0;
            pix_y        <= v_cnt;
            line_start   <= h_first;
            frame_start  <= h_first && v_first;
            if (h_last && v_last)
                frame_count <= frame_count + 8'd1;
        end else begin
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_video_timing.sv
// tb_video_timing: scoreboard bench for video_timing. Two instances share
// stimulus: a reduced raster (25x10, active-low syncs) for whole-frame and
// wrap behaviour, and a default XGA raster with active-high syncs.
module tb_video_timing;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       va;
        logic [9:0] x;
        logic [9:0] y;
        logic       ls;
        logic       fs;
        logic [7:0] fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic pix_en;

    logic       hs_a, vs_a, va_a, ls_a, fs_a;
    logic [9:0] x_a, y_a;
    logic [7:0] fc_a;
    logic       hs_b, vs_b, va_b, ls_b, fs_b;
    logic [9:0] x_b, y_b;
    logic [7:0] fc_b;

    int total = 0;
    int bad   = 0;

    exp_t qa[$];
    exp_t qb[$];
    exp_t last_a, last_b;
    int unsigned idx = 0;

    // measured intervals on the reduced raster / XGA raster
    int ls_cnt = 0, ls_gap = 0;
    int fs_cnt = 0, fs_gap = 0;
    int vs_run = 0, vs_len = 0;
    int hs_run = 0, hs_len = 0;

    always #5 clk = ~clk;

    video_timing #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(6),  .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(1'b0),  .V_POL(1'b0)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .hsync(hs_a), .vsync(vs_a), .video_active(va_a),
        .pix_x(x_a), .pix_y(y_a), .line_start(ls_a),
        .frame_start(fs_a), .frame_count(fc_a)
    );

    video_timing #(
        .H_POL(1'b1), .V_POL(1'b1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .hsync(hs_b), .vsync(vs_b), .video_active(va_b),
        .pix_x(x_b), .pix_y(y_b), .line_start(ls_b),
        .frame_start(fs_b), .frame_count(fc_b)
    );

    // Expected outputs after the edge that presents raster index p
    function automatic exp_t present(input int unsigned p,
        input int unsigned ha, input int unsigned hfp, input int unsigned hsw, input int unsigned hbp,
        input int unsigned va, input int unsigned vfp, input int unsigned vsw, input int unsigned vbp,
        input bit hpol, input bit vpol);
        int unsigned ht, vt, h, v;
        exp_t e;
        ht   = ha + hfp + hsw + hbp;
        vt   = va + vfp + vsw + vbp;
        h    = p % ht;
        v    = (p / ht) % vt;
        e.hs = (h >= ha + hfp && h < ha + hfp + hsw) ? hpol : !hpol;
        e.vs = (v >= va + vfp && v < va + vfp + vsw) ? vpol : !vpol;
        e.va = (h < ha) && (v < va);
        e.x  = (h < ha) ? 10'(h) : 10'd0;
        e.y  = 10'(v);
        e.ls = (h == 0);
        e.fs = (h == 0) && (v == 0);
        e.fc = 8'(((p + 1) / (ht * vt)) % 256);
        return e;
    endfunction

    function automatic exp_t rst_vals(input bit hpol, input bit vpol);
        exp_t e;
        e    = '0;
        e.hs = !hpol;
        e.vs = !vpol;
        return e;
    endfunction

    task automatic cmp(input string nm, input exp_t act, input exp_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t: got hs=%0b vs=%0b va=%0b x=%0d y=%0d ls=%0b fs=%0b fc=%0d, want hs=%0b vs=%0b va=%0b x=%0d y=%0d ls=%0b fs=%0b fc=%0d",
                     nm, $time, act.hs, act.vs, act.va, act.x, act.y, act.ls, act.fs, act.fc,
                     exp.hs, exp.vs, exp.va, exp.x, exp.y, exp.ls, exp.fs, exp.fc);
        end
    endtask

    task automatic dcheck(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    function automatic exp_t act_a();
        return {hs_a, vs_a, va_a, x_a, y_a, ls_a, fs_a, fc_a};
    endfunction

    function automatic exp_t act_b();
        return {hs_b, vs_b, va_b, x_b, y_b, ls_b, fs_b, fc_b};
    endfunction

    // One clk: drive inputs at negedge and queue what the next edge must show
    task automatic cycle(input bit en, input bit rn);
        @(negedge clk);
        pix_en = en;
        rst_n  = rn;
        if (!rn) begin
            idx    = 0;
            last_a = rst_vals(1'b0, 1'b0);
            last_b = rst_vals(1'b1, 1'b1);
        end else if (en) begin
            idx++;
            last_a = present(idx - 1, 16, 2, 4, 3, 6, 1, 2, 1, 1'b0, 1'b0);
            last_b = present(idx - 1, 1024, 24, 136, 160, 768, 3, 6, 29, 1'b1, 1'b1);
        end else begin
            last_a.ls = 1'b0;
            last_a.fs = 1'b0;
            last_b.ls = 1'b0;
            last_b.fs = 1'b0;
        end
        qa.push_back(last_a);
        qb.push_back(last_b);
    endtask

    // Monitor: pop and compare after every edge, and track pulse spacing
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (qa.size() > 0) cmp("raster_a", act_a(), qa.pop_front());
            if (qb.size() > 0) cmp("raster_b", act_b(), qb.pop_front());
            ls_cnt++;
            if (ls_a) begin ls_gap = ls_cnt; ls_cnt = 0; end
            fs_cnt++;
            if (fs_a) begin fs_gap = fs_cnt; fs_cnt = 0; end
            if (vs_a == 1'b0) vs_run++;
            else if (vs_run > 0) begin vs_len = vs_run; vs_run = 0; end
            if (hs_b == 1'b1) hs_run++;
            else if (hs_run > 0) begin hs_len = hs_run; hs_run = 0; end
        end
    end

    initial begin
        rst_n  = 1'b0;
        pix_en = 1'b0;
        last_a = rst_vals(1'b0, 1'b0);
        last_b = rst_vals(1'b1, 1'b1);

        // reset held with enable high
        repeat (3) cycle(1'b1, 1'b0);
        @(posedge clk); #1;
        dcheck("idle_hsync_b_pol1", int'(hs_b), 0);
        dcheck("idle_vsync_b_pol1", int'(vs_b), 0);

        // continuous enable: covers the whole first XGA line
        repeat (1400) cycle(1'b1, 1'b1);

        // enable pattern 1,0,0,1
        repeat (3) begin
            cycle(1'b1, 1'b1);
            cycle(1'b0, 1'b1);
            cycle(1'b0, 1'b1);
            cycle(1'b1, 1'b1);
        end

        // asynchronous reset mid-line, between clock edges
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        cmp("async_rst_a", act_a(), rst_vals(1'b0, 1'b0));
        cmp("async_rst_b", act_b(), rst_vals(1'b1, 1'b1));
        repeat (2) cycle(1'b0, 1'b0);

        // restart: first enabled edge presents (0,0)
        cycle(1'b1, 1'b1);
        @(posedge clk); #1;
        dcheck("first_fs", int'(fs_a), 1);
        dcheck("first_x", int'(x_a), 0);
        dcheck("first_fc", int'(fc_a), 0);

        // second frame_start: frame_count = 1
        repeat (250) cycle(1'b1, 1'b1);
        @(posedge clk); #1;
        dcheck("second_fs", int'(fs_a), 1);
        dcheck("second_fs_y", int'(y_a), 0);
        dcheck("second_fs_fc", int'(fc_a), 1);

        // 256 full frames in total: counter wraps to 0
        repeat (63749) cycle(1'b1, 1'b1);
        @(posedge clk); #1;
        dcheck("fc_wrap", int'(fc_a), 0);
        dcheck("line_gap", ls_gap, 25);
        dcheck("frame_gap", fs_gap, 250);
        dcheck("vsync_len_a", vs_len, 50);
        dcheck("hsync_len_b", hs_len, 136);

        repeat (2) @(posedge clk);
        #1;
        dcheck("queue_drained", qa.size() + qb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
